// File: rtl/vga_pattern_gen_if.sv
// Video output bundle of the pattern generator plus its run-time controls.
// The generator takes the master side; a DAC, board top or bench takes the slave side.
interface vga_pattern_gen_if #(
    parameter int COLOR_BITS = 4
);
    logic [1:0]              mode;
    logic [3*COLOR_BITS-1:0] solid_rgb;
    logic [COLOR_BITS-1:0]   red;
    logic [COLOR_BITS-1:0]   green;
    logic [COLOR_BITS-1:0]   blue;
    logic                    hsync;
    logic                    vsync;
    logic                    de;
    logic                    frame_start;
    logic [15:0]             frame_cnt;

    modport master (
        input  mode, solid_rgb,
        output red, green, blue, hsync, vsync, de, frame_start, frame_cnt
    );

    modport slave (
        output mode, solid_rgb,
        input  red, green, blue, hsync, vsync, de, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator. Counter state (h,v) is turned
// into colour/sync/de one register stage later, so every output describes the same pixel.
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int COLOR_BITS = 4,
    parameter int SQ_LOG2    = 5,
    parameter int GRAD_SHIFT = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_pattern_gen_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = $clog2(BAR_W + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [COLOR_BITS-1:0] FULL = {COLOR_BITS{1'b1}};

    // Counter-side state
    logic [HW-1:0]           h_q, h_d;
    logic [VW-1:0]           v_q, v_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [2:0]              bar_q, bar_d;
    logic [BW-1:0]           sub_q, sub_d;
    logic [1:0]              mode_q, mode_d;
    logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;

    // Output-side state
    logic [COLOR_BITS-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic                    hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [15:0]             fc_q;

    logic h_last, v_last, active, chk_t;
    logic [COLOR_BITS-1:0] pat_r, pat_g, pat_b, grad;

    assign h_last = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);
    assign active = (h_q < H_ACT) && (v_q < V_ACT);

    always_comb begin
        h_d    = h_last ? '0 : h_q + 1'b1;
        v_d    = v_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        rgb_d  = rgb_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + 1'b1;
        end
        // Frame-boundary latch: new selection takes effect at the next (0,0)
        if (h_last && v_last) begin
            cnt_d  = cnt_q + 16'd1;
            mode_d = vga.mode;
            rgb_d  = vga.solid_rgb;
        end
        // Bar index tracks h/BAR_W with a sub-counter instead of a divider
        bar_d = bar_q;
        sub_d = sub_q + 1'b1;
        if (h_last) begin
            bar_d = '0;
            sub_d = '0;
        end else if (sub_q == BAR_LAST) begin
            sub_d = '0;
            bar_d = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        end
    end

    assign chk_t = 1'((16'(h_q) + cnt_q) >> SQ_LOG2) ^ 1'(16'(v_q) >> SQ_LOG2);
    assign grad  = COLOR_BITS'(h_q >> GRAD_SHIFT);

    always_comb begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        case (mode_q)
            2'd0: begin
                pat_r = chk_t ? FULL : '0;
                pat_g = chk_t ? FULL : '0;
                pat_b = chk_t ? FULL : '0;
            end
            2'd1: begin
                // white,yellow,cyan,green,magenta,red,blue,black: r=~b1, g=~b2, b=~b0
                pat_r = bar_q[1] ? '0 : FULL;
                pat_g = bar_q[2] ? '0 : FULL;
                pat_b = bar_q[0] ? '0 : FULL;
            end
            2'd2: begin
                pat_r = grad;
                pat_g = grad;
                pat_b = grad;
            end
            default: begin
                pat_r = rgb_q[3*COLOR_BITS-1 -: COLOR_BITS];
                pat_g = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
                pat_b = rgb_q[COLOR_BITS-1 -: COLOR_BITS];
            end
        endcase
        red_d   = active ? pat_r : '0;
        green_d = active ? pat_g : '0;
        blue_d  = active ? pat_b : '0;
        de_d    = active;
        fs_d    = (h_q == '0) && (v_q == '0);
        hs_d    = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
        vs_d    = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            bar_q   <= '0;
            sub_q   <= '0;
            mode_q  <= '0;
            rgb_q   <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            bar_q   <= bar_d;
            sub_q   <= sub_d;
            mode_q  <= mode_d;
            rgb_q   <= rgb_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            fc_q    <= cnt_q;
        end
    end

    assign vga.red         = red_q;
    assign vga.green       = green_q;
    assign vga.blue        = blue_q;
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.de          = de_q;
    assign vga.frame_start = fs_q;
    assign vga.frame_cnt   = fc_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: full horizontal timing with a short frame; a reference
// model pushes the expected output word per cycle, popped and compared after each edge.
module tb_vga_pattern_gen;
    localparam int HA = 800, HFP = 40, HSW = 128, HBP = 88;
    localparam int VA = 11, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int CB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vga_pattern_gen_if #(.COLOR_BITS(CB)) vif ();

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_BITS(CB), .SQ_LOG2(5), .GRAD_SHIFT(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vga(vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        int h;
        int v;
        int f;
    } item_t;

    item_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_h, m_v, m_cnt;
    logic [1:0] m_mode;
    logic [11:0] m_rgb;
    logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

    // Measurement trackers
    int cyc = 0;
    int fs_cyc, de_cnt, de_rise, hs_rise, vs_rise;
    bit fs_seen, hs_seen, hs_prev, vs_prev, de_prev;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {vif.red, vif.green, vif.blue, vif.hsync, vif.vsync, vif.de,
                vif.frame_start, vif.frame_cnt};
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_cnt = 0; m_mode = 2'd0; m_rgb = 12'h000;
        fs_seen = 0; hs_seen = 0; hs_prev = 0; vs_prev = 0; de_prev = 0;
        de_cnt = 0;
    endtask

    task automatic push_expected();
        item_t it;
        logic [3:0] r, g, b, gr;
        logic [15:0] xs, ys;
        logic [2:0] c;
        logic t, act, hs, vs;
        int bar;
        r = 4'h0; g = 4'h0; b = 4'h0;
        act = (m_h < HA) && (m_v < VA);
        case (m_mode)
            2'd0: begin
                xs = 16'(m_h + m_cnt);
                ys = 16'(m_v);
                t = xs[5] ^ ys[5];
                r = t ? 4'hF : 4'h0; g = r; b = r;
            end
            2'd1: begin
                bar = m_h / (HA / 8);
                if (bar > 7) bar = 7;
                c = bar_tab[bar];
                r = c[2] ? 4'hF : 4'h0;
                g = c[1] ? 4'hF : 4'h0;
                b = c[0] ? 4'hF : 4'h0;
            end
            2'd2: begin
                gr = 4'(m_h >> 5);
                r = gr; g = gr; b = gr;
            end
            default: {r, g, b} = m_rgb;
        endcase
        if (!act) {r, g, b} = 12'h000;
        hs = (m_h >= HA + HFP) && (m_h < HA + HFP + HSW);
        vs = (m_v >= VA + VFP) && (m_v < VA + VFP + VSW);
        it.exp = {r, g, b, hs, vs, act, (m_h == 0 && m_v == 0), 16'(m_cnt)};
        it.h = m_h; it.v = m_v; it.f = m_cnt;
        sb_q.push_back(it);
        if (m_h == HT - 1 && m_v == VT - 1) begin
            m_mode = vif.mode;
            m_rgb  = vif.solid_rgb;
            m_cnt  = (m_cnt + 1) % 65536;
        end
        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h++;
        end
    endtask

    task automatic spot(input item_t it, input logic [31:0] act);
        logic [31:0] rgb;
        rgb = 32'(act[31:20]);
        if (it.v == 0 && it.h == 31 && it.f == 0) chk("scroll_f0", rgb, 32'h000);
        if (it.v == 0 && it.h == 31 && it.f == 1) chk("scroll_f1", rgb, 32'hFFF);
        if (it.v == 8 && it.h == 32 && it.f == 1) chk("switch_hold_chk", rgb, 32'hFFF);
        if (it.v == 8 && it.h == 0  && it.f == 1) chk("switch_hold_blk", rgb, 32'h000);
        if (it.v == 0 && it.h == 0  && it.f == 2) chk("solid_00", rgb, 32'h5A3);
        if (it.f == 3 && it.v == 10) begin
            if (it.h == 0)   chk("bar_x0", rgb, 32'hFFF);
            if (it.h == 100) chk("bar_x100", rgb, 32'hFF0);
            if (it.h == 250) chk("bar_x250", rgb, 32'h0FF);
            if (it.h == 350) chk("bar_x350", rgb, 32'h0F0);
            if (it.h == 799) chk("bar_x799", rgb, 32'h000);
        end
        if (it.f == 4 && it.v == 0) begin
            if (it.h == 0)   chk("grad_x0", rgb, 32'h000);
            if (it.h == 31)  chk("grad_x31", rgb, 32'h000);
            if (it.h == 32)  chk("grad_x32", rgb, 32'h111);
            if (it.h == 544) chk("grad_x544", rgb, 32'h111);
        end
    endtask

    task automatic track(input logic [31:0] act);
        logic hs, vs, de, fs;
        hs = act[19]; vs = act[18]; de = act[17]; fs = act[16];
        if (fs) begin
            if (fs_seen) begin
                chk("fs_period", 32'(cyc - fs_cyc), 32'(FRAME));
                chk("de_per_frame", 32'(de_cnt), 32'(HA * VA));
            end
            fs_seen = 1; fs_cyc = cyc; de_cnt = 0;
        end
        if (de) de_cnt++;
        if (de && !de_prev) de_rise = cyc;
        if (hs && !hs_prev) begin
            if (hs_seen) chk("hs_period", 32'(cyc - hs_rise), 32'(HT));
            else         chk("hs_after_de", 32'(cyc - de_rise), 32'(HA + HFP));
            hs_seen = 1; hs_rise = cyc;
        end
        if (!hs && hs_prev) chk("hs_width", 32'(cyc - hs_rise), 32'(HSW));
        if (vs && !vs_prev) begin
            chk("vs_line", 32'((cyc - fs_cyc) / HT), 32'(VA + VFP));
            vs_rise = cyc;
        end
        if (!vs && vs_prev) chk("vs_width", 32'(cyc - vs_rise), 32'(VSW * HT));
        hs_prev = hs; vs_prev = vs; de_prev = de;
    endtask

    task automatic step();
        item_t it;
        logic [31:0] act;
        push_expected();
        @(posedge clk);
        #1;
        act = dut_vec();
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            it = sb_q.pop_front();
            chk($sformatf("pix f%0d y%0d x%0d", it.f, it.v, it.h), act, it.exp);
            spot(it, act);
        end
        track(act);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (errors > 40) return;
            step();
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.mode = 2'd0;
        vif.solid_rgb = 12'h000;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_init", dut_vec(), 32'h0);
        end
        rst_n = 1'b1;

        // Frames 0/1 checkerboard; switch to solid mid frame 1
        run(FRAME + 3 * HT);
        vif.mode = 2'd3;
        vif.solid_rgb = 12'h5A3;
        // Frame 2 solid; colour bars requested for frame 3
        run(FRAME - HT);
        vif.mode = 2'd1;
        // Frame 3 bars; gradient requested for frame 4
        run(FRAME);
        vif.mode = 2'd2;
        // Into frame 4, line 12, inside hsync and vsync
        run(FRAME - 2 * HT + 12 * HT + 900);

        if (errors <= 40) begin
            vif.mode = 2'd3;
            rst_n = 1'b0;
            #1;
            chk("rst_async", dut_vec(), 32'h0);
            repeat (3) begin
                @(posedge clk);
                #1;
                chk("rst_hold", dut_vec(), 32'h0);
            end
            rst_n = 1'b1;
            model_reset();
            step();
            chk("rst_first", dut_vec(), 32'h0003_0000);
            run(2 * HT);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
